hex_game_sequencer: RTL

//  Sequences the 6-digit HEX text display across one match: mode menu, FIGHT banner,

---
 rtl/hex_game_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/hex_game_sequencer.sv
// hex_game_sequencer: sequences the HEX text display through menu, FIGHT banner, live timer and result.
// Latency: every output is registered and responds one clk edge after the input that caused it.
// Backpressure: none; button pulses outside MENU/RESULT and KO levels outside PLAY are dropped.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   btn_mode, btn_start   1-cycle button pulses (mode toggle / start-continue)
//   p1_ko, p2_ko          KO levels from the game core, honoured only during PLAY
//   hex_state             text decoder selector (0=1P 1=2P 2=FIGHt 3=P1 win 4=P2 win 5=Eq 6=timer)
//   game_duration         elapsed match seconds, saturating at MAX_SECS
//   game_active           high only while the match is live
//   mode_2p               selected mode, 0=1P 1=2P
module hex_game_sequencer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FIGHT_SECS = 2,
  parameter int MAX_SECS   = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       p1_ko,
  input  logic       p2_ko,
  output logic [2:0] hex_state,
  output logic [6:0] game_duration,
  output logic       game_active,
  output logic       mode_2p
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (FIGHT_SECS > 1) ? $clog2(FIGHT_SECS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SEC_LAST = SW'(FIGHT_SECS - 1);
  localparam logic [6:0]    DUR_MAX  = 7'(MAX_SECS);
  localparam logic [6:0]    DUR_LAST = 7'(MAX_SECS - 1);

  localparam logic [2:0] HEX_FIGHT  = 3'd2;
  localparam logic [2:0] HEX_P1_WIN = 3'd3;
  localparam logic [2:0] HEX_P2_WIN = 3'd4;
  localparam logic [2:0] HEX_DRAW   = 3'd5;
  localparam logic [2:0] HEX_TIMER  = 3'd6;

  typedef enum logic [1:0] {
    ST_MENU   = 2'd0,
    ST_FIGHT  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   prescaler, prescaler_nxt;
  logic [SW-1:0]   sec_cnt, sec_cnt_nxt;
  logic [2:0]      hex_nxt;
  logic [6:0]      dur_nxt;
  logic            active_nxt;
  logic            mode_nxt;
  logic            tick;

  // One-second strobe; prescaler restarts on every state entry so the first
  // tick of a state lands exactly CLK_HZ cycles after entering it.
  assign tick = (prescaler == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_MENU;
      prescaler     <= '0;
      sec_cnt       <= '0;
      hex_state     <= 3'd0;
      game_duration <= 7'd0;
      game_active   <= 1'b0;
      mode_2p       <= 1'b0;
    end else begin
      state         <= state_nxt;
      prescaler     <= prescaler_nxt;
      sec_cnt       <= sec_cnt_nxt;
      hex_state     <= hex_nxt;
      game_duration <= dur_nxt;
      game_active   <= active_nxt;
      mode_2p       <= mode_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    prescaler_nxt = '0;          // timebase idles at zero outside timed states
    sec_cnt_nxt   = sec_cnt;
    hex_nxt       = hex_state;
    dur_nxt       = game_duration;
    active_nxt    = 1'b0;
    mode_nxt      = mode_2p;

    case (state)
      ST_MENU: begin
        if (btn_start) begin
          // start wins over a simultaneous mode press
          state_nxt   = ST_FIGHT;
          hex_nxt     = HEX_FIGHT;
          dur_nxt     = 7'd0;
          sec_cnt_nxt = '0;
        end else begin
          if (btn_mode) mode_nxt = ~mode_2p;
          hex_nxt = {2'b00, mode_nxt};
        end
      end

      ST_FIGHT: begin
        hex_nxt       = HEX_FIGHT;
        prescaler_nxt = tick ? '0 : prescaler + 1'b1;
        if (tick) begin
          if (sec_cnt == SEC_LAST) begin
            state_nxt     = ST_PLAY;
            hex_nxt       = HEX_TIMER;
            active_nxt    = 1'b1;
            prescaler_nxt = '0;
            sec_cnt_nxt   = '0;
          end else begin
            sec_cnt_nxt = sec_cnt + 1'b1;
          end
        end
      end

      ST_PLAY: begin
        hex_nxt       = HEX_TIMER;
        active_nxt    = 1'b1;
        prescaler_nxt = tick ? '0 : prescaler + 1'b1;
        // KO outranks a coincident tick, so the final second is not counted
        if (p1_ko || p2_ko) begin
          state_nxt     = ST_RESULT;
          active_nxt    = 1'b0;
          prescaler_nxt = '0;
          if (p1_ko && p2_ko) hex_nxt = HEX_DRAW;
          else if (p2_ko)     hex_nxt = HEX_P1_WIN;
          else                hex_nxt = HEX_P2_WIN;
        end else if (tick) begin
          if (game_duration >= DUR_LAST) begin
            // time limit reached: saturate and declare a draw
            dur_nxt       = DUR_MAX;
            state_nxt     = ST_RESULT;
            hex_nxt       = HEX_DRAW;
            active_nxt    = 1'b0;
            prescaler_nxt = '0;
          end else begin
            dur_nxt = game_duration + 7'd1;
          end
        end
      end

      ST_RESULT: begin
        if (btn_start) begin
          state_nxt = ST_MENU;
          hex_nxt   = {2'b00, mode_2p};
          dur_nxt   = 7'd0;
        end
      end

      default: begin
        state_nxt = ST_MENU;
        hex_nxt   = {2'b00, mode_2p};
        dur_nxt   = 7'd0;
      end
    endcase
  end

endmodule
